// File: rtl/ddr3_frame_reader_if.sv
// Avalon-MM burst read port plus display-FIFO write port of the DDR3 frame reader.
// master: the frame reader; slave: the DDR3 controller / FIFO side.
interface ddr3_frame_reader_if #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 64,
    parameter int BC_W    = 7,
    parameter int USEDW_W = 8
);
    logic [ADDR_W-1:0]  avm_address;
    logic               avm_read;
    logic [BC_W-1:0]    avm_burstcount;
    logic               avm_waitrequest;
    logic [DATA_W-1:0]  avm_readdata;
    logic               avm_readdatavalid;
    logic               fifo_wrreq;
    logic [DATA_W-1:0]  fifo_data;
    logic [USEDW_W-1:0] fifo_wrusedw;

    modport master (
        output avm_address, avm_read, avm_burstcount,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output fifo_wrreq, fifo_data,
        input  fifo_wrusedw
    );

    modport slave (
        input  avm_address, avm_read, avm_burstcount,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  fifo_wrreq, fifo_data,
        output fifo_wrusedw
    );
endinterface

// File: rtl/ddr3_frame_reader.sv
// Read-side DMA: fetches one frame from DDR3 in bursts into the display FIFO.
// Optional ping-pong frame banking via macro DDR3_FRAME_PINGPONG_EN (adds rd_bank output).
module ddr3_frame_reader #(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 64,
    parameter int FRAME_WORDS = 98304,
    parameter int BURST_LEN   = 32,
    parameter int BC_W        = 7,
    parameter int FIFO_DEPTH  = 256,
    parameter int USEDW_W     = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                frame_start,
    input  logic [ADDR_W-1:0]   base_addr,
    ddr3_frame_reader_if.master bus,
    output logic                busy,
    output logic                frame_done,
    output logic                frame_overrun
`ifdef DDR3_FRAME_PINGPONG_EN
    ,
    output logic                rd_bank
`endif
);
    localparam int WL_W = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_REQ,
        ST_DATA
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [WL_W-1:0]   words_left;
    logic [BC_W-1:0]   len_q;
    logic [BC_W-1:0]   beat_cnt;
    logic [BC_W-1:0]   cur_len;
    logic [31:0]       space;
    logic [ADDR_W-1:0] start_addr;
    logic              start_ok;

`ifdef DDR3_FRAME_PINGPONG_EN
    logic bank;
    assign start_addr = bank ? base_addr + ADDR_W'(FRAME_WORDS) : base_addr;
`else
    assign start_addr = base_addr;
`endif

    // A start coinciding with frame_done counts as arriving while busy.
    assign start_ok = frame_start && !frame_done;

    always_comb begin
        cur_len = BC_W'(BURST_LEN);
        if (32'(words_left) < 32'(BURST_LEN))
            cur_len = BC_W'(words_left);
    end

    assign space = 32'(FIFO_DEPTH) - 32'(bus.fifo_wrusedw);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state              <= ST_IDLE;
            cur_addr           <= '0;
            words_left         <= '0;
            len_q              <= '0;
            beat_cnt           <= '0;
            bus.avm_address    <= '0;
            bus.avm_read       <= 1'b0;
            bus.avm_burstcount <= '0;
            bus.fifo_wrreq     <= 1'b0;
            bus.fifo_data      <= '0;
            busy               <= 1'b0;
            frame_done         <= 1'b0;
            frame_overrun      <= 1'b0;
`ifdef DDR3_FRAME_PINGPONG_EN
            bank               <= 1'b0;
            rd_bank            <= 1'b0;
`endif
        end else begin
            frame_done     <= 1'b0;
            bus.fifo_wrreq <= 1'b0;
            frame_overrun  <= frame_start && (busy || frame_done);

            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        cur_addr   <= start_addr;
                        words_left <= WL_W'(FRAME_WORDS);
                        busy       <= 1'b1;
`ifdef DDR3_FRAME_PINGPONG_EN
                        rd_bank    <= bank;
`endif
                        state      <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    // Strictly greater: a burst must never fill the FIFO to the brim.
                    if (space > 32'(cur_len)) begin
                        bus.avm_read       <= 1'b1;
                        bus.avm_address    <= cur_addr;
                        bus.avm_burstcount <= cur_len;
                        len_q              <= cur_len;
                        state              <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (!bus.avm_waitrequest) begin
                        bus.avm_read <= 1'b0;
                        beat_cnt     <= len_q;
                        state        <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (bus.avm_readdatavalid) begin
                        bus.fifo_wrreq <= 1'b1;
                        bus.fifo_data  <= bus.avm_readdata;
                        beat_cnt       <= beat_cnt - BC_W'(1);
                        if (beat_cnt == BC_W'(1)) begin
                            cur_addr   <= cur_addr + ADDR_W'(len_q);
                            words_left <= words_left - WL_W'(len_q);
                            if (words_left == WL_W'(len_q)) begin
                                state      <= ST_IDLE;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
`ifdef DDR3_FRAME_PINGPONG_EN
                                bank       <= ~bank;
`endif
                            end else begin
                                state <= ST_CHECK;
                            end
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr3_frame_reader.sv
// Directed bench for ddr3_frame_reader with FRAME_WORDS=100, BURST_LEN=32.
// Behavioural Avalon slave returns data derived from each word address.
`timescale 1ns/1ps
module tb_ddr3_frame_reader;
    localparam int ADDR_W      = 25;
    localparam int DATA_W      = 64;
    localparam int FRAME_WORDS = 100;
    localparam int BURST_LEN   = 32;
    localparam int BC_W        = 7;
    localparam int FIFO_DEPTH  = 256;
    localparam int USEDW_W     = 8;
    localparam logic [ADDR_W-1:0] BASE = 25'h1000;

    logic              clk = 1'b0;
    logic              rstn;
    logic              frame_start = 1'b0;
    logic [ADDR_W-1:0] base_addr = BASE;
    logic              busy;
    logic              frame_done;
    logic              frame_overrun;
`ifdef DDR3_FRAME_PINGPONG_EN
    logic              rd_bank;
    bit                exp_bank = 1'b0;
`endif

    ddr3_frame_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BC_W(BC_W), .USEDW_W(USEDW_W)) bus ();

    ddr3_frame_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN),
        .BC_W(BC_W), .FIFO_DEPTH(FIFO_DEPTH), .USEDW_W(USEDW_W)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .frame_start(frame_start),
        .base_addr(base_addr),
        .bus(bus),
        .busy(busy),
        .frame_done(frame_done),
        .frame_overrun(frame_overrun)
`ifdef DDR3_FRAME_PINGPONG_EN
        ,
        .rd_bank(rd_bank)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input logic [ADDR_W-1:0] a);
        return 64'hA500_0000_0000_0000 | 64'(a);
    endfunction

    function automatic logic [ADDR_W-1:0] frame_base(input logic [ADDR_W-1:0] a);
`ifdef DDR3_FRAME_PINGPONG_EN
        return exp_bank ? a + ADDR_W'(FRAME_WORDS) : a;
`else
        return a;
`endif
    endfunction

    task automatic bank_flip();
`ifdef DDR3_FRAME_PINGPONG_EN
        exp_bank = ~exp_bank;
`endif
    endtask

    task automatic bank_check(input string tag);
`ifdef DDR3_FRAME_PINGPONG_EN
        check(tag, rd_bank, exp_bank);
`else
        check(tag, busy, 1);
`endif
    endtask

    // Slave model: burst log and address-derived read data
    logic [ADDR_W-1:0] b_addr[$];
    int                b_len[$];
    int                b_rdcyc[$];
    int                b_stable[$];
    int                stall_left = 0;
    bit                slave_active = 1'b0;

    initial begin
        logic [ADDR_W-1:0] a0;
        int                l0;
        int                rdc;
        bit                stable;
        a0 = '0; l0 = 0; rdc = 0; stable = 1'b1;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
        forever begin
            @(negedge clk);
            if (bus.avm_read) begin
                if (rdc == 0) begin
                    a0 = bus.avm_address;
                    l0 = int'(bus.avm_burstcount);
                    stable = 1'b1;
                end else if (bus.avm_address != a0 || int'(bus.avm_burstcount) != l0) begin
                    stable = 1'b0;
                end
                rdc++;
                if (stall_left > 0) begin
                    bus.avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    bus.avm_waitrequest = 1'b0;
                    b_addr.push_back(a0);
                    b_len.push_back(l0);
                    b_rdcyc.push_back(rdc);
                    b_stable.push_back(int'(stable));
                    rdc = 0;
                    slave_active = 1'b1;
                    for (int i = 0; i < l0; i++) begin
                        @(negedge clk);
                        bus.avm_readdatavalid = 1'b1;
                        bus.avm_readdata      = word_of(a0 + ADDR_W'(i));
                    end
                    @(negedge clk);
                    bus.avm_readdatavalid = 1'b0;
                    bus.avm_readdata      = '0;
                    slave_active = 1'b0;
                end
            end
        end
    end

    // FIFO-side monitor
    int                wr_cnt = 0;
    int                done_cnt = 0;
    int                ovr_cnt = 0;
    logic [ADDR_W-1:0] exp_base = BASE;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.fifo_wrreq) begin
                check("fifo_data", bus.fifo_data, word_of(exp_base + ADDR_W'(wr_cnt)));
                wr_cnt++;
            end
            if (frame_done) done_cnt++;
            if (frame_overrun) ovr_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats();
        wr_cnt = 0; done_cnt = 0; ovr_cnt = 0;
        b_addr.delete(); b_len.delete(); b_rdcyc.delete(); b_stable.delete();
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] a);
        base_addr   = a;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && done_cnt < 1; i++) step();
        repeat (5) step();
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    task automatic verify_frame(input string tag, input logic [ADDR_W-1:0] fb);
        int exp_off[4] = '{0, 32, 64, 96};
        int exp_len[4] = '{32, 32, 32, 4};
        check({tag, "_n_bursts"}, b_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < b_addr.size()) begin
                check({tag, "_b_addr"}, b_addr[i], fb + ADDR_W'(exp_off[i]));
                check({tag, "_b_len"}, b_len[i], exp_len[i]);
            end
        end
        check({tag, "_n_words"}, wr_cnt, FRAME_WORDS);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic check_zero(input string p);
        check({p, "_avm_read"}, bus.avm_read, 0);
        check({p, "_avm_address"}, bus.avm_address, 0);
        check({p, "_avm_burstcount"}, bus.avm_burstcount, 0);
        check({p, "_fifo_wrreq"}, bus.fifo_wrreq, 0);
        check({p, "_fifo_data"}, bus.fifo_data, 0);
        check({p, "_busy"}, busy, 0);
        check({p, "_frame_done"}, frame_done, 0);
        check({p, "_frame_overrun"}, frame_overrun, 0);
`ifdef DDR3_FRAME_PINGPONG_EN
        check({p, "_rd_bank"}, rd_bank, 0);
`endif
    endtask

    task automatic start_frame(input string tag);
        clear_stats();
        exp_base = frame_base(BASE);
        pulse_start(BASE);
        check({tag, "_busy_start"}, busy, 1);
        bank_check({tag, "_rd_bank"});
    endtask

    initial begin
        bus.fifo_wrusedw = '0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) step();
        check_zero("rst");
        rstn = 1'b1;
        repeat (2) step();
        check_zero("post_rst");

        // Plain frame, no stalls
        start_frame("t1");
        wait_done("t1");
        verify_frame("t1", exp_base);
        bank_flip();

        // Three wait-states on the first request
        stall_left = 3;
        start_frame("t2");
        wait_done("t2");
        verify_frame("t2", exp_base);
        if (b_rdcyc.size() > 0) begin
            check("t2_read_cycles", b_rdcyc[0], 4);
            check("t2_req_stable", b_stable[0], 1);
        end
        if (b_rdcyc.size() > 1) check("t2_second_read_cycles", b_rdcyc[1], 1);
        bank_flip();

        // FIFO space threshold
        bus.fifo_wrusedw = 8'd240;
        start_frame("t3");
        repeat (20) step();
        check("t3_240_read", bus.avm_read, 0);
        check("t3_240_bursts", b_addr.size(), 0);
        bus.fifo_wrusedw = 8'd224;
        repeat (20) step();
        check("t3_224_read", bus.avm_read, 0);
        check("t3_224_bursts", b_addr.size(), 0);
        check("t3_224_busy", busy, 1);
        bus.fifo_wrusedw = 8'd223;
        wait_done("t3");
        verify_frame("t3", exp_base);
        bus.fifo_wrusedw = '0;
        bank_flip();

        // frame_start mid-frame is ignored apart from the overrun pulse
        start_frame("t4");
        for (int i = 0; i < 1000 && wr_cnt < 40; i++) step();
        pulse_start(25'h2000);
        check("t4_overrun_pulse", frame_overrun, 1);
        base_addr = BASE;
        wait_done("t4");
        verify_frame("t4", exp_base);
        check("t4_overrun_cnt", ovr_cnt, 1);
        bank_flip();

        // frame_start in the frame_done cycle
        start_frame("t5");
        for (int i = 0; i < 3000 && !frame_done; i++) step();
        check("t5_done_seen", frame_done, 1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("t5_overrun_at_done", frame_overrun, 1);
        repeat (20) step();
        check("t5_busy_after", busy, 0);
        check("t5_no_new_burst", b_addr.size(), 4);
        check("t5_n_words", wr_cnt, FRAME_WORDS);
        check("t5_done_cnt", done_cnt, 1);
        bank_flip();

        // Asynchronous reset during DATA
        start_frame("t6");
        for (int i = 0; i < 1000 && wr_cnt < 10; i++) step();
        rstn = 1'b0;
        #1;
        check_zero("t6_rst");
        clear_stats();
`ifdef DDR3_FRAME_PINGPONG_EN
        exp_bank = 1'b0;
`endif
        step();
        rstn = 1'b1;
        for (int i = 0; i < 200 && slave_active; i++) step();
        repeat (5) step();
        check("t6_late_wr", wr_cnt, 0);
        check("t6_late_bursts", b_addr.size(), 0);
        check("t6_late_busy", busy, 0);
        start_frame("t7");
        wait_done("t7");
        verify_frame("t7", exp_base);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
